// File: rtl/lab1_imul_pkg.sv
// ---------------------------------------------------------------------------
// lab1_imul_pkg
//
// Shared declarations for the iterative integer multiplier:
//   imul_state_t        control FSM states (IDLE, CALC, DONE)
//   IMUL_DEFAULT_NBITS  default operand/result width
//   imul_state_char()   one ASCII character per state, used by line-trace
//                       tooling ('I', 'C', 'D')
// ---------------------------------------------------------------------------
package lab1_imul_pkg;

  typedef enum logic [1:0] {
    IMUL_IDLE,
    IMUL_CALC,
    IMUL_DONE
  } imul_state_t;

  localparam int IMUL_DEFAULT_NBITS = 32;

  // Line-trace hook: a trace printer shows msg in, this character, msg out.
  function automatic logic [7:0] imul_state_char(input imul_state_t s);
    case (s)
      IMUL_IDLE: return 8'h49;  // 'I'
      IMUL_CALC: return 8'h43;  // 'C'
      IMUL_DONE: return 8'h44;  // 'D'
      default:   return 8'h3F;  // '?'
    endcase
  endfunction

endpackage

// File: rtl/lab1_imul_int_mul_iter_dpath.sv
// ---------------------------------------------------------------------------
// lab1_imul_int_mul_iter_dpath
//
// Datapath of the iterative shift-add multiplier: operand registers, the
// accumulating result register, the step counter, the shifters and adder.
// All sequencing decisions come from the parent FSM.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high; clears every register
//   i_load         capture a = i_msg[2N-1:N], b = i_msg[N-1:0]; clear result
//                  and count
//   i_step         perform one shift-add step
//   i_add          accumulate a into result during this step
//   i_msg          request message {a, b}
//   o_b_lsb        b_reg[0]
//   o_b_zero       b_reg == 0 (present only when
//                  LAB1_IMUL_INT_MUL_ITER_EARLY_EXIT_EN is defined)
//   o_count_last   count == NBITS-1 (this step is the final one)
//   o_result       accumulated product, low NBITS bits
// ---------------------------------------------------------------------------
module lab1_imul_int_mul_iter_dpath
  import lab1_imul_pkg::*;
#(
  parameter int NBITS = IMUL_DEFAULT_NBITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_add,
  input  logic [2*NBITS-1:0] i_msg,
  output logic               o_b_lsb,
`ifdef LAB1_IMUL_INT_MUL_ITER_EARLY_EXIT_EN
  output logic               o_b_zero,
`endif
  output logic               o_count_last,
  output logic [NBITS-1:0]   o_result
);

  localparam int CNT_W = $clog2(NBITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

  logic [NBITS-1:0] r_a;
  logic [NBITS-1:0] r_b;
  logic [NBITS-1:0] r_result;
  logic [CNT_W-1:0] r_count;

  // The sum wraps at NBITS bits; higher product bits are discarded.
  logic [NBITS-1:0] w_sum;
  assign w_sum = r_result + r_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_count  <= '0;
    end else if (i_load) begin
      r_a      <= i_msg[2*NBITS-1:NBITS];
      r_b      <= i_msg[NBITS-1:0];
      r_result <= '0;
      r_count  <= '0;
    end else if (i_step) begin
      if (i_add) begin
        r_result <= w_sum;
      end
      r_a     <= r_a << 1;
      r_b     <= r_b >> 1;
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_b_lsb      = r_b[0];
`ifdef LAB1_IMUL_INT_MUL_ITER_EARLY_EXIT_EN
  assign o_b_zero     = (r_b == '0);
`endif
  assign o_count_last = (r_count == CNT_LAST);
  assign o_result     = r_result;

endmodule

// File: rtl/lab1_imul_int_mul_iter.sv
// ---------------------------------------------------------------------------
// lab1_imul_int_mul_iter
//
// Parametrised iterative shift-add integer multiplier with val/rdy streams.
// One partial product per cycle; result is the low NBITS bits of a*b, which
// is the same for signed and unsigned operands.
//
// Build option
//   LAB1_IMUL_INT_MUL_ITER_EARLY_EXIT_EN  when defined, CALC finishes as soon
//   as the remaining multiplier bits are all zero (variable latency). The
//   NBITS-step bound still applies. Results are identical in both builds.
//
// Ports
//   clk           clock
//   reset         synchronous, active-high; aborts any in-flight multiply
//   istream_val   request valid
//   istream_rdy   unit can accept a request (IDLE, forced 0 during reset)
//   istream_msg   {a[2N-1:N], b[N-1:0]}, sampled only on the accept edge
//   ostream_val   result valid (DONE, forced 0 during reset)
//   ostream_rdy   sink accepts result
//   ostream_msg   low NBITS of a*b (forced 0 during reset)
//
// Line trace: tools print istream_msg, imul_state_char(r_state), ostream_msg.
// ---------------------------------------------------------------------------
module lab1_imul_int_mul_iter
  import lab1_imul_pkg::*;
#(
  parameter int NBITS = IMUL_DEFAULT_NBITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2*NBITS-1:0] istream_msg,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [NBITS-1:0]   ostream_msg
);

  imul_state_t      r_state;
  logic             r_in_rdy;   // mirrors r_state == IMUL_IDLE
  logic             r_out_val;  // mirrors r_state == IMUL_DONE

  logic             w_load;
  logic             w_step;
  logic             w_add;
  logic             w_b_lsb;
  logic             w_count_last;
  logic             w_calc_exit;
  logic [NBITS-1:0] w_result;

  assign w_load = r_in_rdy && istream_val;

`ifdef LAB1_IMUL_INT_MUL_ITER_EARLY_EXIT_EN
  logic w_b_zero;
  // Once b is exhausted further steps cannot change the result, so leave
  // CALC without touching the datapath.
  assign w_step      = (r_state == IMUL_CALC) && !w_b_zero;
  assign w_calc_exit = w_b_zero || w_count_last;
`else
  assign w_step      = (r_state == IMUL_CALC);
  assign w_calc_exit = w_count_last;
`endif

  assign w_add = w_step && w_b_lsb;

  lab1_imul_int_mul_iter_dpath #(
    .NBITS(NBITS)
  ) u_dpath (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_add        (w_add),
    .i_msg        (istream_msg),
    .o_b_lsb      (w_b_lsb),
`ifdef LAB1_IMUL_INT_MUL_ITER_EARLY_EXIT_EN
    .o_b_zero     (w_b_zero),
`endif
    .o_count_last (w_count_last),
    .o_result     (w_result)
  );

  // Control FSM. DONE always returns through IDLE, so a new request is taken
  // no earlier than one cycle after the result transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IMUL_IDLE;
      r_in_rdy  <= 1'b1;
      r_out_val <= 1'b0;
    end else begin
      case (r_state)
        IMUL_IDLE: begin
          if (istream_val) begin
            r_state  <= IMUL_CALC;
            r_in_rdy <= 1'b0;
          end
        end
        IMUL_CALC: begin
          if (w_calc_exit) begin
            r_state   <= IMUL_DONE;
            r_out_val <= 1'b1;
          end
        end
        IMUL_DONE: begin
          if (ostream_rdy) begin
            r_state   <= IMUL_IDLE;
            r_out_val <= 1'b0;
            r_in_rdy  <= 1'b1;
          end
        end
        default: begin
          r_state   <= IMUL_IDLE;
          r_in_rdy  <= 1'b1;
          r_out_val <= 1'b0;
        end
      endcase
    end
  end

  // Outputs stay quiet for the whole time reset is asserted, including the
  // part of the cycle before the reset edge.
  assign istream_rdy = r_in_rdy && !reset;
  assign ostream_val = r_out_val && !reset;
  assign ostream_msg = reset ? '0 : w_result;

endmodule

// File: tb/tb_lab1_imul_int_mul_iter.sv
// ---------------------------------------------------------------------------
// Bench for lab1_imul_int_mul_iter: one instance at NBITS=32 (index 0) and
// one at NBITS=8 (index 1). A transaction-level model predicts, per cycle,
// istream_rdy, ostream_val and ostream_msg; directed vectors pin the model
// with hand-computed results and latencies.
// ---------------------------------------------------------------------------
module tb_lab1_imul_int_mul_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  src_val;
  logic [1:0]  snk_rdy;
  wire  [1:0]  in_rdy;
  wire  [1:0]  out_val;
  logic [63:0] src_msg0;
  logic [15:0] src_msg1;
  wire  [31:0] out_msg0;
  wire  [7:0]  out_msg1;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  lab1_imul_int_mul_iter #(.NBITS(32)) u_dut32 (
    .clk         (clk),
    .reset       (rst),
    .istream_val (src_val[0]),
    .istream_rdy (in_rdy[0]),
    .istream_msg (src_msg0),
    .ostream_val (out_val[0]),
    .ostream_rdy (snk_rdy[0]),
    .ostream_msg (out_msg0)
  );

  lab1_imul_int_mul_iter #(.NBITS(8)) u_dut8 (
    .clk         (clk),
    .reset       (rst),
    .istream_val (src_val[1]),
    .istream_rdy (in_rdy[1]),
    .istream_msg (src_msg1),
    .ostream_val (out_val[1]),
    .ostream_rdy (snk_rdy[1]),
    .ostream_msg (out_msg1)
  );

  // Expected latencies (edges from accept to the edge that raises ostream_val)
`ifdef LAB1_IMUL_INT_MUL_ITER_EARLY_EXIT_EN
  localparam int L_B4   = 4;   // b=4: msb index 2
  localparam int L_B7   = 4;   // b=7: msb index 2
  localparam int L_B11  = 5;   // b=11: msb index 3
  localparam int L8_B16 = 6;   // 8-bit, b=0x10 / 0x11: msb index 4
`else
  localparam int L_B4   = 32;
  localparam int L_B7   = 32;
  localparam int L_B11  = 32;
  localparam int L8_B16 = 8;
`endif

  function automatic int nb(input int k);
    return (k == 0) ? 32 : 8;
  endfunction

  function automatic logic [63:0] mask(input int k);
    return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_00FF;
  endfunction

  function automatic logic [63:0] op_a(input int k);
    return (k == 0) ? {32'b0, src_msg0[63:32]} : {56'b0, src_msg1[15:8]};
  endfunction

  function automatic logic [63:0] op_b(input int k);
    return (k == 0) ? {32'b0, src_msg0[31:0]} : {56'b0, src_msg1[7:0]};
  endfunction

  function automatic logic [63:0] get_out(input int k);
    return (k == 0) ? {32'b0, out_msg0} : {56'b0, out_msg1};
  endfunction

  task automatic set_msg(input int k, input logic [63:0] a, input logic [63:0] b);
    if (k == 0) src_msg0 = {a[31:0], b[31:0]};
    else        src_msg1 = {a[7:0], b[7:0]};
  endtask

  // Accept-to-valid latency from the multiplier's rules.
  function automatic int lat_of(input int k, input logic [63:0] b);
    int n;
    int m;
    n = nb(k);
    m = -1;
    for (int i = 0; i < n; i++) if (b[i]) m = i;
`ifdef LAB1_IMUL_INT_MUL_ITER_EARLY_EXIT_EN
    if (m < 0) return 1;
    return (m + 2 < n) ? m + 2 : n;
`else
    return (m >= -1) ? n : n;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Model: one transaction in flight per instance.
  bit          busy [2];
  int          age  [2];
  int          lat  [2];
  logic [63:0] expr [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        busy[k] = 1'b0;
      end else if (busy[k]) begin
        if (age[k] >= lat[k] && snk_rdy[k]) busy[k] = 1'b0;
        else age[k] = age[k] + 1;
      end else if (src_val[k]) begin
        busy[k] = 1'b1;
        age[k]  = 0;
        lat[k]  = lat_of(k, op_b(k));
        expr[k] = (op_a(k) * op_b(k)) & mask(k);
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    #2;
    if (mon_on) begin
      for (int k = 0; k < 2; k++) begin
        logic rdy_m;
        logic val_m;
        rdy_m = !busy[k] && !rst;
        val_m = busy[k] && (age[k] >= lat[k]) && !rst;
        chk((k == 0) ? "rdy32" : "rdy8", in_rdy[k], rdy_m);
        chk((k == 0) ? "val32" : "val8", out_val[k], val_m);
        if (val_m || rst)
          chk((k == 0) ? "msg32" : "msg8", get_out(k), rst ? 64'd0 : expr[k]);
      end
    end
  end

  // One full transaction. Starts and ends on a negedge.
  task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b,
                        input int sdly, input int hold,
                        output logic [63:0] res, output int lt);
    int n;
    repeat (sdly) @(negedge clk);
    set_msg(k, a, b);
    src_val[k] = 1'b1;
    if (hold > 0) snk_rdy[k] = 1'b0;
    n = 0;
    while (!in_rdy[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy[k]) begin
      fail("accept");
      src_val[k] = 1'b0;
      snk_rdy[k] = 1'b1;
      res = '0;
      lt  = -1;
      return;
    end
    @(negedge clk);
    src_val[k] = 1'b0;
    set_msg(k, {$urandom, $urandom}, {$urandom, $urandom});
    lt = 0;
    while (!out_val[k] && lt < 200) begin
      @(negedge clk);
      lt++;
    end
    if (!out_val[k]) begin
      fail("result");
      snk_rdy[k] = 1'b1;
      res = '0;
      return;
    end
    res = get_out(k);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold rdy", in_rdy[k], 1'b0);
      chk("hold val", out_val[k], 1'b1);
    end
    snk_rdy[k] = 1'b1;
    @(negedge clk);
    chk("idle after xfer", {in_rdy[k], out_val[k]}, 2'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    logic [63:0] a;
    logic [63:0] b;
    int          lt;
    int          nval;

    rst      = 1'b1;
    src_val  = 2'b00;
    snk_rdy  = 2'b11;
    src_msg0 = '0;
    src_msg1 = '0;

    @(negedge clk);
    #1;
    chk("reset rdy32", in_rdy[0], 1'b0);
    chk("reset val32", out_val[0], 1'b0);
    chk("reset msg32", get_out(0), 64'd0);
    chk("reset rdy8", in_rdy[1], 1'b0);
    @(negedge clk);
    rst    = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk("idle rdy32", in_rdy[0], 1'b1);

    // Basic NBITS=32 vectors
    run_op(0, 64'd3, 64'd4, 0, 0, res, lt);
    chk("3x4", res, 64'd12);
    chk("lat 3x4", lt, L_B4);
    run_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0, res, lt);
    chk("ffxff", res, 64'h1);
    chk("lat ffxff", lt, 32);
    run_op(0, 64'hFFFF_FFFB, 64'd7, 0, 0, res, lt);
    chk("-5x7", res, 64'hFFFF_FFDD);
    chk("lat -5x7", lt, L_B7);

`ifdef LAB1_IMUL_INT_MUL_ITER_EARLY_EXIT_EN
    run_op(0, 64'd5, 64'd0, 0, 0, res, lt);
    chk("5x0", res, 64'd0);
    chk("lat b=0", lt, 1);
    run_op(0, 64'd5, 64'd1, 0, 0, res, lt);
    chk("5x1", res, 64'd5);
    chk("lat b=1", lt, 2);
`endif

    // Backpressure: 10 cycles held in DONE
    run_op(0, 64'd9, 64'd11, 0, 10, res, lt);
    chk("9x11", res, 64'd99);
    chk("lat 9x11", lt, L_B11);

    // Mid-operation reset
    set_msg(0, 64'd3, 64'h8000_0005);
    src_val[0] = 1'b1;
    @(negedge clk);
    src_val[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst rdy", in_rdy[0], 1'b0);
    chk("midrst val", out_val[0], 1'b0);
    chk("midrst msg", get_out(0), 64'd0);
    @(negedge clk);
    rst  = 1'b0;
    nval = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_val[0]) nval++;
    end
    chk("no result after reset", nval, 0);
    run_op(0, 64'd6, 64'd7, 0, 0, res, lt);
    chk("6x7", res, 64'd42);
    chk("lat 6x7", lt, L_B7);

    // NBITS=8 vectors
    run_op(1, 64'h10, 64'h10, 0, 0, res, lt);
    chk("8b 10x10", res, 64'h00);
    chk("8b lat 10x10", lt, L8_B16);
    run_op(1, 64'h0F, 64'h11, 0, 0, res, lt);
    chk("8b 0fx11", res, 64'hFF);
    chk("8b lat 0fx11", lt, L8_B16);

    // Random streams with source and sink delays
    for (int i = 0; i < 500; i++) begin
      a = {32'b0, $urandom};
      case ($urandom_range(0, 7))
        0:       b = 64'd0;
        1:       b = 64'd1;
        default: b = {32'b0, $urandom >> $urandom_range(0, 31)};
      endcase
      run_op(0, a, b, $urandom_range(0, 5), $urandom_range(0, 5), res, lt);
      chk("rnd32", res, (a * b) & mask(0));
    end
    for (int i = 0; i < 150; i++) begin
      a = {56'b0, 8'($urandom)};
      b = {56'b0, 8'($urandom >> $urandom_range(0, 7))};
      run_op(1, a, b, $urandom_range(0, 5), $urandom_range(0, 5), res, lt);
      chk("rnd8", res, (a * b) & mask(1));
    end

    repeat (2) @(negedge clk);
    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
